// File: rtl/cla_pkg.sv
// Shared definitions for the sequential carry-lookahead adder:
// FSM state encoding, default geometry and chunk-index sizing.
package cla_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam int unsigned DefaultWidth = 32;
  localparam int unsigned DefaultChunk = 4;

  // Width of the chunk index; at least one bit even when there is a single chunk.
  function automatic int unsigned idx_width(input int unsigned n_chunks);
    return (n_chunks > 1) ? $clog2(n_chunks) : 1;
  endfunction

endpackage

// File: rtl/cla_carry_unit.sv
// Combinational lookahead carry unit for one CHUNK-bit group.
// Every carry is a flat sum-of-products of p, g and the group carry-in,
// so no carry depends on another carry of the same group.
module cla_carry_unit
  import cla_pkg::*;
#(
  parameter int unsigned CHUNK = DefaultChunk
) (
  input  logic [CHUNK-1:0] p,
  input  logic [CHUNK-1:0] g,
  input  logic             ci,
  output logic [CHUNK:0]   c,
  output logic             grp_p,
  output logic             grp_g
);

  // Carry out of bit j: OR over i<=j of g[i]&p[i+1..j], plus ci&p[0..j].
  function automatic logic carry_term(input logic [CHUNK-1:0] pv,
                                      input logic [CHUNK-1:0] gv,
                                      input logic             cin_v,
                                      input int               j);
    logic acc;
    logic term;
    acc = 1'b0;
    for (int i = 0; i < CHUNK; i++) begin
      if (i <= j) begin
        term = gv[i];
        for (int m = 0; m < CHUNK; m++) begin
          if ((m > i) && (m <= j)) term = term & pv[m];
        end
        acc = acc | term;
      end
    end
    term = cin_v;
    for (int m = 0; m < CHUNK; m++) begin
      if (m <= j) term = term & pv[m];
    end
    return acc | term;
  endfunction

  assign c[0] = ci;

  for (genvar j = 0; j < CHUNK; j++) begin : g_carry
    assign c[j+1] = carry_term(p, g, ci, j);
  end

  assign grp_p = &p;
  assign grp_g = carry_term(p, g, 1'b0, CHUNK - 1);

endmodule

// File: rtl/cla_seq_adder.sv
// Multi-cycle carry-lookahead adder: latches A, B and cin, resolves CHUNK
// bits per cycle through one lookahead carry unit, then holds sum/cout
// until the consumer takes them.
// Optional feature: define OVERFLOW_EN to add the registered signed
// overflow output ovf.
module cla_seq_adder
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned CHUNK = DefaultChunk
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned NChunks = (CHUNK == 0) ? 1 : WIDTH / CHUNK;
  localparam int unsigned KW      = idx_width(NChunks);
  localparam logic [KW-1:0] LastK = KW'(NChunks - 1);

  if ((CHUNK == 0) || ((WIDTH % CHUNK) != 0)) begin : g_param_check
    $error("cla_seq_adder: WIDTH must be a non-zero multiple of CHUNK");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [KW-1:0]    k_q, k_d;

  logic [CHUNK-1:0] a_chunk, b_chunk;
  logic [CHUNK-1:0] p_chunk, g_chunk, s_chunk;
  logic [CHUNK:0]   c_chunk;
  logic             grp_p, grp_g;
  logic             chunk_cout;

  // Select the operand bits of the chunk currently being resolved.
  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int i = 0; i < NChunks; i++) begin
      if (k_q == KW'(i)) begin
        a_chunk = a_q[i*CHUNK +: CHUNK];
        b_chunk = b_q[i*CHUNK +: CHUNK];
      end
    end
  end

  // Per-bit full-adder cells: propagate, generate and sum.
  for (genvar j = 0; j < CHUNK; j++) begin : g_cell
    assign p_chunk[j] = a_chunk[j] | b_chunk[j];
    assign g_chunk[j] = a_chunk[j] & b_chunk[j];
    assign s_chunk[j] = a_chunk[j] ^ b_chunk[j] ^ c_chunk[j];
  end

  cla_carry_unit #(
    .CHUNK(CHUNK)
  ) u_carry (
    .p    (p_chunk),
    .g    (g_chunk),
    .ci   (carry_q),
    .c    (c_chunk),
    .grp_p(grp_p),
    .grp_g(grp_g)
  );

  // Group carry-out formed from the group signals rather than the last carry.
  assign chunk_cout = grp_g | (grp_p & carry_q);

`ifdef OVERFLOW_EN
  logic ovf_q, ovf_d;
  logic unused_c_top;
  assign unused_c_top = c_chunk[CHUNK];
`else
  logic unused_c_top;
  assign unused_c_top = c_chunk[CHUNK];
`endif

  // Next-state logic: accept in IDLE, one chunk per RUN cycle, hold in DONE.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    k_d     = k_q;
`ifdef OVERFLOW_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          k_d     = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        for (int i = 0; i < NChunks; i++) begin
          if (k_q == KW'(i)) sum_d[i*CHUNK +: CHUNK] = s_chunk;
        end
        carry_d = chunk_cout;
        k_d     = k_q + 1'b1;
        if (k_q == LastK) begin
          cout_d  = chunk_cout;
`ifdef OVERFLOW_EN
          ovf_d   = c_chunk[CHUNK-1] ^ chunk_cout;
`endif
          k_d     = '0;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset discards any partial result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      k_q     <= k_d;
    end
  end

`ifdef OVERFLOW_EN
  // Overflow flag register, captured with cout on the final chunk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end
  assign ovf = ovf_q;
`endif

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_cla_seq_adder.sv
// Self-checking bench for cla_seq_adder: two instances (32/4 and 16/16),
// a cycle-level behavioural model per instance, directed literal cases and
// randomized traffic with random back-pressure.
module tb_cla_seq_adder;

  localparam int W0 = 32;
  localparam int C0 = 4;
  localparam int LAT0 = W0 / C0 + 1;
  localparam int W1 = 16;
  localparam int C1 = 16;
  localparam int LAT1 = W1 / C1 + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          in_valid0 = 1'b0, in_ready0, cin0 = 1'b0, out_valid0, out_ready0 = 1'b0, cout0;
  logic [W0-1:0] a0 = '0, b0 = '0, sum0;
  logic          in_valid1 = 1'b0, in_ready1, cin1 = 1'b0, out_valid1, out_ready1 = 1'b0, cout1;
  logic [W1-1:0] a1 = '0, b1 = '0, sum1;
`ifdef OVERFLOW_EN
  logic ovf0, ovf1;
  logic last_ovf0;
`endif

  int checks = 0;
  int failures = 0;

  cla_seq_adder #(.WIDTH(W0), .CHUNK(C0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
    .a(a0), .b(b0), .cin(cin0), .out_valid(out_valid0), .out_ready(out_ready0),
    .sum(sum0), .cout(cout0)
`ifdef OVERFLOW_EN
    , .ovf(ovf0)
`endif
  );

  cla_seq_adder #(.WIDTH(W1), .CHUNK(C1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .cout(cout1)
`ifdef OVERFLOW_EN
    , .ovf(ovf1)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: age counts cycles since accept (accept cycle = 1),
  // -1 when idle. Result is A+B+cin at full precision.
  int            age0, age1;
  logic [W0:0]   exp0;
  logic [W1:0]   exp1;
  logic          expovf0, expovf1;
  int            done0 = 0, done1 = 0;

  function automatic logic sovf(input logic sa, input logic sb, input logic ss);
    return (sa == sb) && (ss != sa);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age0 <= -1;
    end else if (age0 < 0) begin
      if (in_valid0) begin
        age0    <= 1;
        exp0    <= {1'b0, a0} + {1'b0, b0} + {{W0{1'b0}}, cin0};
        expovf0 <= sovf(a0[W0-1], b0[W0-1], (a0 + b0 + {{(W0-1){1'b0}}, cin0}) >> (W0 - 1) != 0);
      end
    end else if (age0 >= LAT0) begin
      if (out_ready0) age0 <= -1;
    end else begin
      age0 <= age0 + 1;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age1 <= -1;
    end else if (age1 < 0) begin
      if (in_valid1) begin
        age1    <= 1;
        exp1    <= {1'b0, a1} + {1'b0, b1} + {{W1{1'b0}}, cin1};
        expovf1 <= sovf(a1[W1-1], b1[W1-1], (a1 + b1 + {{(W1-1){1'b0}}, cin1}) >> (W1 - 1) != 0);
      end
    end else if (age1 >= LAT1) begin
      if (out_ready1) age1 <= -1;
    end else begin
      age1 <= age1 + 1;
    end
  end

  // Compare process: handshake signals every cycle, result while it must be valid.
  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready0", in_ready0, age0 < 0);
      check("out_valid0", out_valid0, age0 >= LAT0);
      if (age0 >= LAT0) begin
        check("result0", {cout0, sum0}, exp0);
`ifdef OVERFLOW_EN
        check("ovf0", ovf0, expovf0);
`endif
        if (out_ready0) done0 <= done0 + 1;
      end
      check("in_ready1", in_ready1, age1 < 0);
      check("out_valid1", out_valid1, age1 >= LAT1);
      if (age1 >= LAT1) begin
        check("result1", {cout1, sum1}, exp1);
`ifdef OVERFLOW_EN
        check("ovf1", ovf1, expovf1);
`endif
        if (out_ready1) done1 <= done1 + 1;
      end
    end
  end

  // One directed operation on the 32-bit instance; call at #1 after a posedge while idle.
  task automatic op0(input logic [W0-1:0] ta, input logic [W0-1:0] tb_v, input logic tc,
                     input int stall, input logic poke,
                     output logic [W0-1:0] s, output logic co, output int lat);
    a0 = ta; b0 = tb_v; cin0 = tc; in_valid0 = 1'b1; out_ready0 = 1'b0;
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    lat = 1;
    while (!out_valid0 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    s = sum0;
    co = cout0;
`ifdef OVERFLOW_EN
    last_ovf0 = ovf0;
`endif
    for (int i = 0; i < stall; i++) begin
      if (poke) begin
        in_valid0 = 1'b1; a0 = $urandom; b0 = $urandom; cin0 = 1'b1;
      end
      @(posedge clk); #1;
      if (poke) begin
        check("bp_sum_stable", sum0, s);
        check("bp_cout_stable", cout0, co);
        check("bp_in_ready_low", in_ready0, 1'b0);
      end
    end
    in_valid0 = 1'b0;
    out_ready0 = 1'b1;
    @(posedge clk); #1;
    out_ready0 = 1'b0;
  endtask

  task automatic rand0(input int n);
    int cyc = 0;
    int mode;
    while (done0 < n && cyc < 60000) begin
      mode = $urandom_range(0, 5);
      a0 = $urandom;
      b0 = (mode == 3) ? ~a0 : $urandom;
      if (mode == 4) begin a0 = '1; b0 = '0; end
      if (mode == 5) begin a0 = 32'h7FFF_FFFF; b0 = $urandom_range(0, 3); end
      cin0 = $urandom_range(0, 1);
      in_valid0 = $urandom_range(0, 1);
      out_ready0 = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
      cyc++;
    end
    in_valid0 = 1'b0;
    out_ready0 = 1'b0;
    check("rand0_completed", done0, n);
  endtask

  task automatic rand1(input int n);
    int cyc = 0;
    int mode;
    while (done1 < n && cyc < 60000) begin
      mode = $urandom_range(0, 4);
      a1 = W1'($urandom);
      b1 = (mode == 3) ? ~a1 : W1'($urandom);
      if (mode == 4) begin a1 = '1; b1 = '0; end
      cin1 = $urandom_range(0, 1);
      in_valid1 = $urandom_range(0, 1);
      out_ready1 = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
      cyc++;
    end
    in_valid1 = 1'b0;
    out_ready1 = 1'b0;
    check("rand1_completed", done1, n);
  endtask

  logic [W0-1:0] s;
  logic          co;
  int            lat;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready0, 1'b1);
    check("rst_out_valid", out_valid0, 1'b0);
    check("rst_sum", sum0, '0);
    check("rst_cout", cout0, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic add with latency pin.
    op0(32'h5, 32'h3, 1'b0, 0, 1'b0, s, co, lat);
    check("basic_sum", s, 32'h8);
    check("basic_cout", co, 1'b0);
    check("basic_latency", lat, 9);

    // Full carry chain.
    op0(32'hFFFF_FFFF, 32'h0, 1'b1, 0, 1'b0, s, co, lat);
    check("chain_sum", s, 32'h0);
    check("chain_cout", co, 1'b1);
`ifdef OVERFLOW_EN
    check("chain_ovf", last_ovf0, 1'b0);
`endif

    // Signed overflow boundary.
    op0(32'h7FFF_FFFF, 32'h1, 1'b0, 0, 1'b0, s, co, lat);
    check("ovf_case_sum", s, 32'h8000_0000);
    check("ovf_case_cout", co, 1'b0);
`ifdef OVERFLOW_EN
    check("ovf_case_ovf", last_ovf0, 1'b1);
`endif

    // Back-pressure for 20 cycles with operands poked while busy.
    op0(32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 20, 1'b1, s, co, lat);
    check("bp_sum", s, 32'hF0E2_1568);
    check("bp_cout", co, 1'b0);
    check("bp_idle_after", in_ready0, 1'b1);

    // Reset during the third RUN cycle.
    a0 = 32'h1111_1111; b0 = 32'h2222_2222; cin0 = 1'b0; in_valid0 = 1'b1;
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("midrun_out_valid", out_valid0, 1'b0);
    check("midrun_sum", sum0, '0);
    check("midrun_in_ready", in_ready0, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    op0(32'h1, 32'h1, 1'b0, 0, 1'b0, s, co, lat);
    check("after_reset_sum", s, 32'h2);

    fork
      rand0(3000);
      rand1(6000);
    join

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
